// File: rtl/router_pkg.sv
// Shared router definitions: datapath width, FIFO depth, header field
// positions and the packet-counter width. Imported by the FIFO, the
// synchronizer and the FSM so all three agree on header layout.
package router_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned FIFO_DEPTH = 16;

   // Header byte layout: payload length in [7:2], destination in [1:0]
   localparam int unsigned LEN_MSB  = 7;
   localparam int unsigned LEN_LSB  = 2;
   localparam int unsigned ADDR_MSB = 1;
   localparam int unsigned ADDR_LSB = 0;

   localparam int unsigned PKT_CNT_W = LEN_MSB - LEN_LSB + 1;

   typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

   // Bytes remaining after a header: payload length plus the parity byte
   function automatic pkt_cnt_t hdr_count(input logic [7:0] hdr);
      return hdr[LEN_MSB:LEN_LSB] + pkt_cnt_t'(1);
   endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-port output FIFO of the 1x3 router. Stores
// {lfd_state, data_in} words and serves them with one cycle of read
// latency, tracking packet boundaries so data_out idles at 0 between
// packets.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset, clears all state
//   soft_reset - synchronous flush (pointers, counter, data_out)
//   write_enb  - write strobe from the synchronizer
//   read_enb   - read strobe from the destination
//   lfd_state  - marks data_in as a header byte
//   data_in    - byte to store
//   data_out   - registered read data, 0 between packets
//   full       - all DEPTH entries occupied
//   empty      - no entries occupied
module router_fifo #(
   parameter int unsigned DEPTH  = router_pkg::FIFO_DEPTH,
   parameter int unsigned DATA_W = router_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              soft_reset,
   input  logic              write_enb,
   input  logic              read_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty
);

   import router_pkg::*;

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   typedef logic [DATA_W:0] word_t;

   word_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   pkt_cnt_t         pkt_cnt;

   logic  wr_ok;
   logic  rd_ok;
   word_t rd_word;

   // Extra MSB is the wrap bit: equal pointers mean empty, equal low
   // bits with differing wrap bits mean full.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign wr_ok   = write_enb && !full;
   assign rd_ok   = read_enb && !empty;
   assign rd_word = mem[rd_ptr[AW-1:0]];

   // Storage has no reset; contents are don't-care after a flush
   always_ff @(posedge clock) begin
      if (wr_ok && !soft_reset) begin
         mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
      end else if (soft_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            data_out <= rd_word[DATA_W-1:0];
            // Header word reloads the count; body bytes count it down
            if (rd_word[DATA_W]) begin
               pkt_cnt <= hdr_count(rd_word[7:0]);
            end else if (pkt_cnt != '0) begin
               pkt_cnt <= pkt_cnt - pkt_cnt_t'(1);
            end
         end else if (pkt_cnt == '0) begin
            data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

   localparam int DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int n_checks = 0;
   int n_fail   = 0;

   router_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
      .clock(clock), .reset(reset), .soft_reset(soft_reset),
      .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
      .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
   );

   always #5 clock = ~clock;

   // Behavioural model: a queue of stored words plus a count of bytes
   // remaining in the packet currently being read.
   logic [8:0] q[$];
   int         m_cnt = 0;
   logic [7:0] m_dout = '0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         q.delete();
         m_cnt  = 0;
         m_dout = '0;
      end else if (soft_reset) begin
         q.delete();
         m_cnt  = 0;
         m_dout = '0;
      end else begin
         bit rd_ok, wr_ok;
         logic [8:0] w;
         rd_ok = read_enb && (q.size() != 0);
         wr_ok = write_enb && (q.size() != DEPTH);
         if (rd_ok) begin
            w = q.pop_front();
            m_dout = w[7:0];
            if (w[8]) m_cnt = (int'(w[7:2]) + 1) % 64;
            else if (m_cnt != 0) m_cnt = m_cnt - 1;
         end else if (m_cnt == 0) begin
            m_dout = '0;
         end
         if (wr_ok) q.push_back({lfd_state, data_in});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, mid-cycle
   always @(negedge clock) begin
      check("data_out", 32'(data_out), 32'(m_dout));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("pkt_cnt", 32'(dut.pkt_cnt), 32'(m_cnt));
   end

   task automatic step(input logic w, input logic r, input logic l,
                       input logic [7:0] d, input logic sr = 1'b0);
      write_enb = w; read_enb = r; lfd_state = l; data_in = d; soft_reset = sr;
      @(posedge clock);
      #1;
      write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; data_in = '0; soft_reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_t1 [5];
      exp_t1[0] = 8'h0C; exp_t1[1] = 8'h11; exp_t1[2] = 8'h22;
      exp_t1[3] = 8'h33; exp_t1[4] = 8'h44;

      #1 reset = 1'b1;
      @(posedge clock); @(posedge clock); #1;
      check("reset data_out", 32'(data_out), 32'h0);
      check("reset empty", 32'(empty), 32'h1);
      check("reset full", 32'(full), 32'h0);
      reset = 1'b0;

      // Single packet: header len 3 + 3 bytes + parity
      step(1, 0, 1, 8'h0C);
      check("empty after 1st write", 32'(empty), 32'h0);
      step(1, 0, 0, 8'h11);
      step(1, 0, 0, 8'h22);
      step(1, 0, 0, 8'h33);
      step(1, 0, 0, 8'h44);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 8'h00);
         check("pkt byte", 32'(data_out), 32'(exp_t1[i]));
      end
      check("pkt_cnt after parity", 32'(dut.pkt_cnt), 32'h0);
      step(0, 0, 0, 8'h00);
      check("idle after packet", 32'(data_out), 32'h0);
      check("empty after packet", 32'(empty), 32'h1);

      // Fill to full, overflow write dropped, drain
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0, 8'hA0 + 8'(i));
         if (i == 14) check("full after 15", 32'(full), 32'h0);
      end
      check("full after 16", 32'(full), 32'h1);
      step(1, 0, 0, 8'hFF);
      check("full after dropped", 32'(full), 32'h1);
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0, 8'h00);
         if (i == 0)  check("first drained", 32'(data_out), 32'hA0);
         if (i == 15) check("last drained", 32'(data_out), 32'hAF);
      end
      check("empty after drain", 32'(empty), 32'h1);

      // Half full, simultaneous read/write across the pointer wrap
      for (int i = 0; i < 8; i++) step(1, 0, 0, 8'h50 + 8'(i));
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 0, 8'h60 + 8'(i));
         check("rw data", 32'(data_out), 32'h50 + i);
         check("rw occupancy", 32'(q.size()), 32'd8);
      end
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 8'h00);
         check("post-wrap data", 32'(data_out), 32'h60 + i);
      end

      // Read while empty, then write+read in the same cycle
      step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      check("read empty data_out", 32'(data_out), 32'h0);
      check("read empty empty", 32'(empty), 32'h1);
      step(1, 1, 0, 8'h77);
      check("wr+rd on empty data", 32'(data_out), 32'h0);
      check("wr+rd on empty empty", 32'(empty), 32'h0);
      step(0, 1, 0, 8'h00);
      check("byte after wr+rd", 32'(data_out), 32'h77);

      // Soft reset mid-packet with 5 entries stored
      step(1, 0, 1, 8'h10);
      for (int i = 1; i <= 5; i++) step(1, 0, 0, 8'(i));
      step(0, 1, 0, 8'h00);
      check("hdr before flush", 32'(data_out), 32'h10);
      step(0, 0, 0, 8'h00, 1'b1);
      check("flush empty", 32'(empty), 32'h1);
      check("flush full", 32'(full), 32'h0);
      check("flush data_out", 32'(data_out), 32'h0);
      step(1, 0, 1, 8'h04);
      step(1, 0, 0, 8'hAB);
      step(1, 0, 0, 8'hCD);
      step(0, 1, 0, 8'h00); check("new pkt hdr", 32'(data_out), 32'h04);
      step(0, 1, 0, 8'h00); check("new pkt body", 32'(data_out), 32'hAB);
      step(0, 1, 0, 8'h00); check("new pkt parity", 32'(data_out), 32'hCD);
      step(0, 0, 0, 8'h00); check("new pkt idle", 32'(data_out), 32'h0);

      // Async reset between edges mid-packet
      step(1, 0, 1, 8'h0C);
      step(1, 0, 0, 8'h21);
      step(1, 0, 0, 8'h22);
      step(0, 1, 0, 8'h00);
      check("hdr before async", 32'(data_out), 32'h0C);
      #2 reset = 1'b1;
      #1;
      check("async data_out", 32'(data_out), 32'h0);
      check("async empty", 32'(empty), 32'h1);
      check("async full", 32'(full), 32'h0);
      check("async pkt_cnt", 32'(dut.pkt_cnt), 32'h0);
      #2 reset = 1'b0;
      step(0, 1, 0, 8'h00);
      check("after async read", 32'(data_out), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
